// File: rtl/cdc_sync_fifo.sv
// Single-clock show-ahead FIFO with ready/valid handshakes on both ports.
// Define CDC_SYNC_FIFO_ERR_FLAGS_EN to add sticky ovf/udf error outputs.
module cdc_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    wput,
  output logic                    wrdy,
  output logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    rget,
  output logic                    rrdy,
  output logic [$clog2(DEPTH):0]  level
`ifdef CDC_SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                    ovf,
  output logic                    udf
`endif
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE        = (AW+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wptr_q, wptr_d;
  logic [AW:0]           rptr_q, rptr_d;
  logic [AW:0]           level_q, level_d;
  logic                  push, pop;

  // Handshake flags depend only on registered occupancy, never on wput/rget.
  assign wrdy  = (level_q != FULL_LEVEL);
  assign rrdy  = (level_q != '0);
  assign push  = wput && wrdy;
  assign pop   = rget && rrdy;
  assign level = level_q;
  assign rdata = rrdy ? mem_q[rptr_q[AW-1:0]] : '0;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push) wptr_d = wptr_q + ONE;
    if (pop)  rptr_d = rptr_q + ONE;
    case ({push, pop})
      2'b10:   level_d = level_q + ONE;
      2'b01:   level_d = level_q - ONE;
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; cleared pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

`ifdef CDC_SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (wput & ~wrdy);
    udf_d = udf_q | (rget & ~rrdy);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_cdc_sync_fifo.sv
// Self-checking bench for cdc_sync_fifo against a queue-based occupancy model.
// Covers the optional CDC_SYNC_FIFO_ERR_FLAGS_EN error flags when the macro is defined.
module tb_cdc_sync_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int LW = $clog2(DEPTH) + 1;
`ifdef CDC_SYNC_FIFO_ERR_FLAGS_EN
  localparam int VW = 2 + LW + DW + 2;
`else
  localparam int VW = 2 + LW + DW;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          wput = 1'b0;
  logic          rget = 1'b0;
  logic          wrdy, rrdy;
  logic [DW-1:0] rdata;
  logic [LW-1:0] level;
`ifdef CDC_SYNC_FIFO_ERR_FLAGS_EN
  logic          ovf, udf;
`endif

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf;

  always #5 clk = ~clk;

  cdc_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wdata (wdata),
    .wput  (wput),
    .wrdy  (wrdy),
    .rdata (rdata),
    .rget  (rget),
    .rrdy  (rrdy),
    .level (level)
`ifdef CDC_SYNC_FIFO_ERR_FLAGS_EN
    ,
    .ovf   (ovf),
    .udf   (udf)
`endif
  );

  logic [VW-1:0] dut_vec;
`ifdef CDC_SYNC_FIFO_ERR_FLAGS_EN
  assign dut_vec = {wrdy, rrdy, level, rdata, ovf, udf};
`else
  assign dut_vec = {wrdy, rrdy, level, rdata};
`endif

  // Expected outputs derived purely from the model queue contents.
  function automatic logic [VW-1:0] exp_vec();
    logic [LW-1:0] lvl;
    logic [DW-1:0] head;
    lvl  = LW'(q.size());
    head = (q.size() != 0) ? q[0] : '0;
`ifdef CDC_SYNC_FIFO_ERR_FLAGS_EN
    return {q.size() != DEPTH, q.size() != 0, lvl, head, m_ovf, m_udf};
`else
    return {q.size() != DEPTH, q.size() != 0, lvl, head};
`endif
  endfunction

  // Drive one cycle of stimulus, advance the model at the edge, settle 1 time unit after.
  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit rn);
    bit push_ok, pop_ok;
    wput = w; wdata = d; rget = r; rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      push_ok = w && (q.size() < DEPTH);
      pop_ok  = r && (q.size() > 0);
      if (w && !push_ok) m_ovf = 1'b1;
      if (r && !pop_ok)  m_udf = 1'b1;
      if (pop_ok)  void'(q.pop_front());
      if (push_ok) q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    checks++;
    if ({wrdy, rrdy, level, rdata} !== {1'b1, 1'b0, LW'(0), 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", {wrdy, rrdy, level, rdata},
               {1'b1, 1'b0, LW'(0), 8'h00});
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if ({rrdy, level} !== {1'b0, LW'(0)}) begin
      errors++;
      $display("FAIL reset_nothing_stored: got rrdy=%b level=%0d expected rrdy=0 level=0", rrdy, level);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL fill_%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if ({wrdy, level} !== {1'b0, LW'(DEPTH)}) begin
      errors++;
      $display("FAIL fill_full: got wrdy=%b level=%0d expected wrdy=0 level=%0d", wrdy, level, DEPTH);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if (rdata !== DW'(i)) begin
        errors++;
        $display("FAIL drain_data_%0d: got %h expected %h", i, rdata, DW'(i));
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b1);
    end
    checks++;
    if ({rrdy, level} !== {1'b0, LW'(0)}) begin
      errors++;
      $display("FAIL drain_empty: got rrdy=%b level=%0d expected rrdy=0 level=0", rrdy, level);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, DW'(i), 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 8'hAA, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL overflow_%0d: got %h expected %h", k, dut_vec, exp_vec());
      end
    end
    checks++;
    if ({level, rdata} !== {LW'(DEPTH), 8'h01}) begin
      errors++;
      $display("FAIL overflow_hold: got level=%0d rdata=%h expected level=%0d rdata=01", level, rdata, DEPTH);
    end
`ifdef CDC_SYNC_FIFO_ERR_FLAGS_EN
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b expected 1", ovf);
    end
`endif
  endtask

  task automatic test_full_push_pop();
    cyc(1'b1, 8'h55, 1'b1, 1'b1);
    checks++;
    if ({wrdy, level, rdata} !== {1'b1, LW'(DEPTH - 1), 8'h02}) begin
      errors++;
      $display("FAIL full_push_pop: got wrdy=%b level=%0d rdata=%h expected wrdy=1 level=%0d rdata=02",
               wrdy, level, rdata, DEPTH - 1);
    end
    while (q.size() != 0) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL full_drain: got %h expected %h", dut_vec, exp_vec());
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b1);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL empty_pop: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_streaming();
    int bad = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1'b1, DW'($urandom), 1'b1, 1'b1);
      checks++;
      if (dut_vec !== exp_vec() || level > 1) begin
        errors++;
        bad++;
        if (bad < 5) $display("FAIL stream_%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(bit'($urandom_range(0, 99) < 55), DW'($urandom), bit'($urandom_range(0, 99) < 45), 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        bad++;
        if (bad < 5) $display("FAIL random_%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_mid_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'($urandom), 1'b0, 1'b1);
    checks++;
    if (level !== LW'(5)) begin
      errors++;
      $display("FAIL mid_level5: got %0d expected 5", level);
    end
    cyc(1'b1, 8'hEE, 1'b1, 1'b0);
    checks++;
    if ({rrdy, level, rdata} !== {1'b0, LW'(0), 8'h00}) begin
      errors++;
      $display("FAIL mid_reset: got rrdy=%b level=%0d rdata=%h expected 0 0 00", rrdy, level, rdata);
    end
    cyc(1'b1, 8'h3C, 1'b0, 1'b1);
    checks++;
    if ({rrdy, level, rdata} !== {1'b1, LW'(1), 8'h3C}) begin
      errors++;
      $display("FAIL mid_after_push: got rrdy=%b level=%0d rdata=%h expected 1 1 3c", rrdy, level, rdata);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL mid_model: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_streaming();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
